mem_port_arbiter: RTL

- Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port, so the SoC can run from a unified memory instead of split inst/data memories.
- Fixed priority favours data accesses, with a starvation limit that guarantees instruction fetch progress.
- Sits between the riscv core's inst_*/data_* buses and a unified memory with 1-cycle registered read latency.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous memory between the core's
//               instruction-fetch port and its load/store port. Data accesses
//               win by fixed priority; a starvation counter forces a fetch
//               grant after STARVE_LIMIT consecutive data grants.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active-low
  // instruction-fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  // load/store port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  // unified memory
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          busy
);

  localparam logic [CNT_W-1:0] c_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;      // consecutive data grants while fetch waited
  logic            r_own_d;    // 1 = current owner is the data port
  logic            r_rd;       // 1 = current access is a read
  logic [DW-1:0]   r_i_rdata;  // fetch read data held between acks
  logic [DW-1:0]   r_d_rdata;  // data read data held between acks
  logic            w_grant_d;

  // Data wins a contended IDLE edge unless fetch has been starved to the limit
  assign w_grant_d = d_req & (~i_req | (r_cnt != c_STARVE_LIMIT));

  // The memory output register is loaded at the ISSUE->RESP edge, so during
  // RESP the owner sees that word directly; afterwards the hold register keeps it
  assign i_rdata = (r_state == ST_RESP && !r_own_d) ? mem_rdata : r_i_rdata;
  assign d_rdata = (r_state == ST_RESP && r_own_d && r_rd) ? mem_rdata : r_d_rdata;

  // Arbitration state machine with registered memory-side and ack outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_own_d   <= 1'b0;
      r_rd      <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            r_state <= ST_ISSUE;
            busy    <= 1'b1;
            mem_ce  <= 1'b1;
            r_own_d <= w_grant_d;
            if (w_grant_d) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              r_rd      <= ~d_we;
              if (i_req) begin
                if (r_cnt != c_STARVE_LIMIT) r_cnt <= r_cnt + CNT_W'(1);
              end else begin
                r_cnt <= '0;
              end
            end else begin
              mem_addr <= i_addr;
              mem_we   <= 1'b0;
              r_rd     <= 1'b1;
              r_cnt    <= '0;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_RESP;
          mem_ce  <= 1'b0;
          mem_we  <= 1'b0;
          i_ack   <= ~r_own_d;
          d_ack   <= r_own_d;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
          if (r_rd) begin
            if (r_own_d) r_d_rdata <= mem_rdata;
            else         r_i_rdata <= mem_rdata;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          mem_ce  <= 1'b0;
          mem_we  <= 1'b0;
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
